tc_alu_bist_ctrl: RTL

TC_ALU_BIST_CTRL -- requirements
Module: tc_alu_bist_ctrl

---
 rtl/tc_alu_bist_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/tc_alu_bist_ctrl.sv
// ============================================================================
// tc_alu_bist_ctrl : sequencing FSM for the ALU BIST datapath (seed/run/check)
// Rev 1.0
// ============================================================================
`default_nettype none

module tc_alu_bist_ctrl #(
    parameter int NUM_VECT = 32,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic             START,
    input  logic             LOOP,
    input  logic             ABORT,
    input  logic             PASS_N,
    output logic             TEST_EN,
    output logic             SET_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] FAIL_CNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEED   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_VECT - 1);
    localparam logic [CNT_W-1:0] C_MAX  = '1;

    state_t           r_state;
    state_t           w_nxt;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (START) w_nxt = S_SEED;
            S_SEED:   w_nxt = S_SETTLE;
            S_SETTLE: w_nxt = S_RUN;
            S_RUN:    if (r_cnt == C_LAST) w_nxt = S_CHECK;
            S_CHECK:  w_nxt = S_DONE;
            S_DONE:   w_nxt = LOOP ? S_SEED : S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
        // ABORT wins over START and LOOP, and also blocks leaving IDLE
        if (ABORT) w_nxt = S_IDLE;
    end

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            TEST_EN  <= 1'b0;
            SET_EN   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            FAIL_CNT <= '0;
        end else begin
            r_state <= w_nxt;
            TEST_EN <= (w_nxt == S_SEED) || (w_nxt == S_SETTLE) ||
                       (w_nxt == S_RUN)  || (w_nxt == S_CHECK);
            SET_EN  <= (w_nxt == S_SEED);
            BUSY    <= (w_nxt != S_IDLE);
            DONE    <= (w_nxt == S_DONE);

            if ((r_state == S_RUN) && (w_nxt == S_RUN))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            if ((r_state == S_CHECK) && (w_nxt == S_DONE)) begin
                PASS <= ~PASS_N;
                if (PASS_N && (FAIL_CNT != C_MAX))
                    FAIL_CNT <= FAIL_CNT + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
